keccak_arbiter: RTL and testbench

Shares one `keccak` hash core between `NREQ` requesters in the ROLLO encrypt datapath, for example the E(z) hash and the shared-secret hash. The block arbitrates round-robin and starts the core for the winner. While that job runs it routes the core's memory-read port to the winner's operand memory. It captures the 512-bit digest and returns it with a per-requester done pulse. A watchdog ends any job the core never completes.

---
 rtl/keccak_arbiter.sv | 128 ++++++++++++
 tb/tb_keccak_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/keccak_arbiter.sv
// Round-robin arbiter that shares one keccak core between NREQ requesters.
// Routes the winner's operand memory to the core and returns its digest.
module keccak_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 64,
  parameter int AW    = 4,
  parameter int TMO   = 4096
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_mem_din,
  output logic [AW-1:0]         req_mem_addr,
  output logic [NREQ-1:0]       req_mem_en,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic [511:0]          digest,
  output logic                  core_in_ready,
  output logic [WIDTH-1:0]      core_mem_din,
  input  logic [AW-1:0]         core_mem_addr,
  input  logic [511:0]          core_out,
  input  logic                  core_out_ready
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TMO);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  localparam logic [WW-1:0] WD_MAX = WW'(TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   last_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            err_q;
  logic [511:0]    digest_q;
  logic            start_q;
  logic [WW-1:0]   wdog_q;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;

  // Search starts just after the previous winner, so it has lowest priority.
  always_comb begin
    int cand;
    pick_vld = 1'b0;
    pick_idx = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_q) + k) % NREQ;
      if (!pick_vld && req[IW'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q  <= S_IDLE;
      last_q   <= IW'(NREQ - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      digest_q <= '0;
      start_q  <= 1'b0;
      wdog_q   <= '0;
    end else begin
      done_q  <= '0;
      start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            gnt_q   <= ONE << pick_idx;
            last_q  <= pick_idx;
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          wdog_q  <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          if (core_out_ready) begin
            digest_q <= core_out;
            err_q    <= 1'b0;
            done_q   <= gnt_q;
            state_q  <= S_DONE;
          end else if (wdog_q == WD_MAX) begin
            err_q   <= 1'b1;
            done_q  <= gnt_q;
            state_q <= S_DONE;
          end else begin
            wdog_q <= wdog_q + WW'(1);
          end
        end
        S_DONE: begin
          gnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    core_mem_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) core_mem_din |= req_mem_din[i*WIDTH +: WIDTH];
    end
  end

  assign req_mem_addr  = core_mem_addr;
  assign req_mem_en    = gnt_q;
  assign gnt           = gnt_q;
  assign done          = done_q;
  assign err           = err_q;
  assign digest        = digest_q;
  assign core_in_ready = start_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter: job table plus reset,
// withdrawal, mux and idle-ignore sequences.
module tb_keccak_arbiter;

  localparam int TMO = 16;
  localparam logic [63:0] S0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] S1 = 64'hFEDC_BA98_7654_3210;

  logic         clk;
  logic         rst_b;
  logic [1:0]   req;
  logic [127:0] req_mem_din;
  logic [3:0]   req_mem_addr;
  logic [1:0]   req_mem_en;
  logic [1:0]   gnt;
  logic [1:0]   done;
  logic         err;
  logic [511:0] digest;
  logic         core_in_ready;
  logic [63:0]  core_mem_din;
  logic [3:0]   core_mem_addr;
  logic [511:0] core_out;
  logic         core_out_ready;

  keccak_arbiter #(
    .NREQ (2),
    .WIDTH(64),
    .AW   (4),
    .TMO  (TMO)
  ) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .req           (req),
    .req_mem_din   (req_mem_din),
    .req_mem_addr  (req_mem_addr),
    .req_mem_en    (req_mem_en),
    .gnt           (gnt),
    .done          (done),
    .err           (err),
    .digest        (digest),
    .core_in_ready (core_in_ready),
    .core_mem_din  (core_mem_din),
    .core_mem_addr (core_mem_addr),
    .core_out      (core_out),
    .core_out_ready(core_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]   rq;
    int           lat;
    bit           tmo;
    bit           keep;
    logic [511:0] dout;
    logic [1:0]   egnt;
    logic         eerr;
    logic [511:0] edig;
  } vec_t;

  vec_t vt [9];

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck, want finish");
    $fatal(1);
  end

  initial begin
    int e;
    int exp_e;

    vt[0] = '{2'b11, 12, 1'b0, 1'b1, {64{8'h11}}, 2'b01, 1'b0, {64{8'h11}}};
    vt[1] = '{2'b11, 3, 1'b0, 1'b1, {64{8'h22}}, 2'b10, 1'b0, {64{8'h22}}};
    vt[2] = '{2'b11, 0, 1'b0, 1'b1, {64{8'h33}}, 2'b01, 1'b0, {64{8'h33}}};
    vt[3] = '{2'b11, TMO-1, 1'b0, 1'b1, {64{8'h44}}, 2'b10, 1'b0, {64{8'h44}}};
    vt[4] = '{2'b11, TMO-2, 1'b0, 1'b1, {64{8'h55}}, 2'b01, 1'b0, {64{8'h55}}};
    vt[5] = '{2'b11, 7, 1'b0, 1'b1, {64{8'h66}}, 2'b10, 1'b0, {64{8'h66}}};
    vt[6] = '{2'b01, 10, 1'b0, 1'b0, {64{8'hA5}}, 2'b01, 1'b0, {64{8'hA5}}};
    vt[7] = '{2'b10, 0, 1'b1, 1'b0, {64{8'h77}}, 2'b10, 1'b1, {64{8'hA5}}};
    vt[8] = '{2'b01, 4, 1'b0, 1'b0, {64{8'h88}}, 2'b01, 1'b0, {64{8'h88}}};

    rst_b          = 1'b1;
    req            = 2'b00;
    req_mem_din    = {S1, S0};
    core_mem_addr  = 4'd0;
    core_out       = '0;
    core_out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst gnt", gnt, 2'b00);
    chk("rst done", done, 2'b00);
    chk("rst err", err, 1'b0);
    chk("rst digest", digest, '0);
    chk("rst cir", core_in_ready, 1'b0);
    chk("rst mux", core_mem_din, 64'h0);
    rst_b = 1'b0;

    // completion strobe outside BUSY must be ignored
    core_out       = {64{8'hFF}};
    core_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle done", done, 2'b00);
    chk("idle digest", digest, '0);
    chk("idle gnt", gnt, 2'b00);
    core_out_ready = 1'b0;

    for (int i = 0; i < 9; i++) begin
      req         = vt[i].rq;
      req_mem_din = {S1, S0};
      @(negedge clk);
      chk($sformatf("v%0d gnt", i), gnt, vt[i].egnt);
      chk($sformatf("v%0d en", i), req_mem_en, vt[i].egnt);
      chk($sformatf("v%0d cir", i), core_in_ready, 1'b1);
      chk($sformatf("v%0d mux", i), core_mem_din,
          vt[i].egnt[0] ? S0 : S1);
      @(negedge clk);
      chk($sformatf("v%0d cir_off", i), core_in_ready, 1'b0);
      for (e = 0; e <= TMO + 4; e++) begin
        if (e > 0) @(negedge clk);
        if (done != 2'b00) break;
        core_out_ready = !vt[i].tmo && (e == vt[i].lat);
        core_out       = vt[i].dout;
      end
      core_out_ready = 1'b0;
      exp_e = vt[i].tmo ? TMO : vt[i].lat + 1;
      chk($sformatf("v%0d latency", i), 512'(e), 512'(exp_e));
      chk($sformatf("v%0d done", i), done, vt[i].egnt);
      chk($sformatf("v%0d err", i), err, vt[i].eerr);
      chk($sformatf("v%0d digest", i), digest, vt[i].edig);
      if (!vt[i].keep) req = 2'b00;
      @(negedge clk);
      chk($sformatf("v%0d done_off", i), done, 2'b00);
      chk($sformatf("v%0d gnt_off", i), gnt, 2'b00);
    end

    // requester 1 wins, mux check, then withdraws mid-job
    req = 2'b10;
    @(negedge clk);
    core_mem_addr = 4'd3;
    req_mem_din   = {64'h0000_0000_DEAD_BEEF, 64'h0};
    #1;
    chk("mux gnt", gnt, 2'b10);
    chk("mux en", req_mem_en, 2'b10);
    chk("mux addr", req_mem_addr, 4'd3);
    chk("mux data", core_mem_din, 64'h0000_0000_DEAD_BEEF);
    @(negedge clk);
    req = 2'b00;
    repeat (3) @(negedge clk);
    core_out       = {64{8'hC3}};
    core_out_ready = 1'b1;
    @(negedge clk);
    core_out_ready = 1'b0;
    chk("wd done", done, 2'b10);
    chk("wd digest", digest, {64{8'hC3}});
    chk("wd err", err, 1'b0);
    @(negedge clk);
    chk("wd done_off", done, 2'b00);

    // asynchronous reset in the middle of a job
    req_mem_din = {S1, S0};
    req         = 2'b01;
    @(negedge clk);
    chk("mr gnt", gnt, 2'b01);
    repeat (3) @(negedge clk);
    chk("mr mux_pre", core_mem_din, S0);
    rst_b = 1'b1;
    #1;
    chk("mr gnt0", gnt, 2'b00);
    chk("mr done0", done, 2'b00);
    chk("mr err0", err, 1'b0);
    chk("mr digest0", digest, '0);
    chk("mr cir0", core_in_ready, 1'b0);
    chk("mr mux0", core_mem_din, 64'h0);
    @(negedge clk);
    rst_b = 1'b0;
    req   = 2'b11;
    @(negedge clk);
    chk("mr regnt", gnt, 2'b01);
    chk("mr recir", core_in_ready, 1'b1);
    req = 2'b00;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
